// File: rtl/led_ctrl_pkg.sv
// ============================================================================
// Module      : led_ctrl_pkg
// Description : Shared FSM/source encodings and config-word field indices.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package led_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CLEAR = 2'b01,
    RUN   = 2'b10,
    DRAIN = 2'b11
  } state_e;

  localparam logic SRC_BOARD = 1'b0;
  localparam logic SRC_VIO   = 1'b1;

  localparam int RATE_LSB  = 0;
  localparam int RATE_W    = 3;
  localparam int COLOR_BIT = 3;

  // Counter width able to hold 0..n-1, never narrower than one bit
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sw_debounce.sv
// ============================================================================
// Module      : sw_debounce
// Description : 2-flop synchronizer plus stability counter for board switches.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sw_debounce
  import led_ctrl_pkg::*;
#(
  parameter int NB_SW           = 4,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NB_SW-1:0] i_sw,
  output logic [NB_SW-1:0] o_sw_db
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] c_cnt_last = CW'(DEBOUNCE_CYCLES - 1);

  logic [NB_SW-1:0] r_sync1;
  logic [NB_SW-1:0] r_sync2;
  logic [NB_SW-1:0] r_cand;
  logic [NB_SW-1:0] r_stable;
  logic [CW-1:0]    r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_cand   <= '0;
      r_stable <= '0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= i_sw;
      r_sync2 <= r_sync1;
      // Counter parks at its last value, so a stable input keeps it saturated
      if (r_sync2 != r_cand) begin
        r_cand <= r_sync2;
        r_cnt  <= '0;
      end else if (r_cnt == c_cnt_last) begin
        r_stable <= r_cand;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_sw_db = r_stable;

endmodule

`default_nettype wire

// File: rtl/led_seq_ctrl.sv
// ============================================================================
// Module      : led_seq_ctrl
// Description : LED sequencer control FSM with board/VIO config arbitration.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_seq_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int NB_SW           = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int DRAIN_MAX       = 255
) (
  input  logic             clock,
  input  logic             i_reset,
  input  logic [NB_SW-1:0] i_sw,
  input  logic             i_sel_vio,
  input  logic [NB_SW-1:0] i_sw_vio,
  input  logic             i_reset_vio,
  input  logic             i_tick,
  output logic             o_run,
  output logic             o_clear,
  output logic [2:0]       o_rate,
  output logic             o_color,
  output logic             o_src,
  output logic [1:0]       o_state,
  output logic             o_cfg_upd
);

  localparam int DW = cnt_width(DRAIN_MAX + 1);
  localparam logic [DW-1:0] c_drain_max = DW'(DRAIN_MAX);
  localparam logic [DW-1:0] c_drain_one = DW'(1);

  logic [NB_SW-1:0]  w_sw_db;
  logic [NB_SW-1:0]  w_sel_cfg;
  logic [NB_SW-1:0]  w_load_cfg;
  logic              w_vio_reset;

  state_e            r_state;
  logic              r_run;
  logic              r_clear;
  logic [RATE_W-1:0] r_rate;
  logic [RATE_W-1:0] r_pend_rate;
  logic              r_color;
  logic              r_src;
  logic              r_cfg_upd;
  logic [DW-1:0]     r_drain_cnt;

  sw_debounce #(
    .NB_SW           (NB_SW),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_sw_debounce (
    .clk     (clock),
    .rst     (i_reset),
    .i_sw    (i_sw),
    .o_sw_db (w_sw_db)
  );

  // Running config follows the owning source; CLEAR loads from the requested one
  assign w_sel_cfg   = (r_src == SRC_VIO) ? i_sw_vio : w_sw_db;
  assign w_load_cfg  = (i_sel_vio == SRC_VIO) ? i_sw_vio : w_sw_db;
  assign w_vio_reset = (r_src == SRC_VIO) && i_reset_vio;

  always_ff @(posedge clock) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_run       <= 1'b0;
      r_clear     <= 1'b0;
      r_rate      <= '0;
      r_pend_rate <= '0;
      r_color     <= 1'b0;
      r_src       <= SRC_BOARD;
      r_cfg_upd   <= 1'b0;
      r_drain_cnt <= '0;
    end else begin
      r_cfg_upd <= 1'b0;
      case (r_state)
        IDLE: begin
          r_state <= CLEAR;
          r_clear <= 1'b1;
          r_run   <= 1'b0;
        end
        CLEAR: begin
          r_state     <= RUN;
          r_clear     <= 1'b0;
          r_run       <= 1'b1;
          r_src       <= i_sel_vio;
          r_rate      <= w_load_cfg[RATE_LSB +: RATE_W];
          r_pend_rate <= w_load_cfg[RATE_LSB +: RATE_W];
          r_color     <= w_load_cfg[COLOR_BIT];
          r_drain_cnt <= '0;
        end
        RUN: begin
          if (i_sel_vio != r_src) begin
            // Entry cycle already counts as the first DRAIN cycle
            r_state     <= DRAIN;
            r_drain_cnt <= c_drain_one;
          end else if (w_vio_reset) begin
            r_state <= CLEAR;
            r_clear <= 1'b1;
            r_run   <= 1'b0;
          end else begin
            r_color     <= w_sel_cfg[COLOR_BIT];
            r_pend_rate <= w_sel_cfg[RATE_LSB +: RATE_W];
            if (i_tick && (r_pend_rate != r_rate)) begin
              r_rate    <= r_pend_rate;
              r_cfg_upd <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (i_sel_vio == r_src) begin
            r_state     <= RUN;
            r_drain_cnt <= '0;
          end else if (w_vio_reset || i_tick || (r_drain_cnt == c_drain_max)) begin
            r_state     <= CLEAR;
            r_clear     <= 1'b1;
            r_run       <= 1'b0;
            r_drain_cnt <= '0;
          end else begin
            r_drain_cnt <= r_drain_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_run   <= 1'b0;
          r_clear <= 1'b0;
        end
      endcase
    end
  end

  assign o_run     = r_run;
  assign o_clear   = r_clear;
  assign o_rate    = r_rate;
  assign o_color   = r_color;
  assign o_src     = r_src;
  assign o_state   = r_state;
  assign o_cfg_upd = r_cfg_upd;

endmodule

`default_nettype wire

// File: tb/tb_led_seq_ctrl.sv
// ============================================================================
// Module      : tb_led_seq_ctrl
// Description : Directed self-checking bench for led_seq_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_led_seq_ctrl;
  import led_ctrl_pkg::*;

  logic       clock;
  logic       i_reset;
  logic [3:0] i_sw;
  logic       i_sel_vio;
  logic [3:0] i_sw_vio;
  logic       i_reset_vio;
  logic       i_tick;
  logic       o_run;
  logic       o_clear;
  logic [2:0] o_rate;
  logic       o_color;
  logic       o_src;
  logic [1:0] o_state;
  logic       o_cfg_upd;

  int n_checks = 0;
  int n_fail   = 0;

  led_seq_ctrl #(
    .NB_SW           (4),
    .DEBOUNCE_CYCLES (8),
    .DRAIN_MAX       (20)
  ) dut (
    .clock       (clock),
    .i_reset     (i_reset),
    .i_sw        (i_sw),
    .i_sel_vio   (i_sel_vio),
    .i_sw_vio    (i_sw_vio),
    .i_reset_vio (i_reset_vio),
    .i_tick      (i_tick),
    .o_run       (o_run),
    .o_clear     (o_clear),
    .o_rate      (o_rate),
    .o_color     (o_color),
    .o_src       (o_src),
    .o_state     (o_state),
    .o_cfg_upd   (o_cfg_upd)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_all(input string tag, input logic [1:0] st, input logic run,
                            input logic clr, input logic [2:0] rate, input logic color,
                            input logic src, input logic upd);
    check({tag, ".state"}, 32'(o_state),   32'(st));
    check({tag, ".run"},   32'(o_run),     32'(run));
    check({tag, ".clear"}, 32'(o_clear),   32'(clr));
    check({tag, ".rate"},  32'(o_rate),    32'(rate));
    check({tag, ".color"}, 32'(o_color),   32'(color));
    check({tag, ".src"},   32'(o_src),     32'(src));
    check({tag, ".upd"},   32'(o_cfg_upd), 32'(upd));
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    i_reset = 1'b1; i_sw = 4'b0101; i_sel_vio = 1'b0; i_sw_vio = 4'b0000;
    i_reset_vio = 1'b0; i_tick = 1'b0;
    step(); step();
    expect_all("reset", IDLE, 0, 0, 3'b000, 0, 0, 0);

    // Reset release: IDLE -> CLEAR -> RUN, debounced rate not yet settled
    i_reset = 1'b0;
    check("rel_idle", 32'(o_state), 32'(IDLE));
    step(); expect_all("rel_clear", CLEAR, 0, 1, 3'b000, 0, 0, 0);
    step(); expect_all("rel_run",   RUN,   1, 0, 3'b000, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      step();
      check("settle_rate", 32'(o_rate), 32'h0);
      check("settle_upd",  32'(o_cfg_upd), 32'h0);
    end
    i_tick = 1'b1;
    step(); expect_all("first_tick", RUN, 1, 0, 3'b101, 0, 0, 1);
    i_tick = 1'b0;
    step(); expect_all("first_tick_after", RUN, 1, 0, 3'b101, 0, 0, 0);

    // New stable board value, applied at the next tick
    i_sw = 4'b0001;
    repeat (13) step();
    check("pend_no_tick", 32'(o_rate), 32'h5);
    i_tick = 1'b1;
    step(); expect_all("board_tick", RUN, 1, 0, 3'b001, 0, 0, 1);

    // Short glitch must never reach the rate, even with ticks every cycle
    for (int i = 0; i < 20; i++) begin
      i_sw = (i < 5) ? 4'b0010 : 4'b0001;
      step();
      check("glitch_rate", 32'(o_rate), 32'h1);
      check("glitch_upd",  32'(o_cfg_upd), 32'h0);
    end
    i_tick = 1'b0;

    // Switch to VIO, tick after 7 DRAIN cycles
    i_sw_vio = 4'b1011; i_sel_vio = 1'b1;
    step(); expect_all("to_vio_drain", DRAIN, 1, 0, 3'b001, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      step();
      check("vio_drain_hold", 32'(o_state), 32'(DRAIN));
    end
    i_tick = 1'b1;
    step(); expect_all("vio_clear", CLEAR, 0, 1, 3'b001, 0, 0, 0);
    i_tick = 1'b0;
    step(); expect_all("vio_run", RUN, 1, 0, 3'b011, 1, 1, 0);

    // Color follows immediately, no tick needed
    i_sw_vio = 4'b0011;
    step(); expect_all("color_off", RUN, 1, 0, 3'b011, 0, 1, 0);
    i_sw_vio = 4'b1011;
    step(); check("color_on", 32'(o_color), 32'h1);

    // Tick, source change and rate change together: source change wins
    i_sw_vio = 4'b1110; i_tick = 1'b1; i_sel_vio = 1'b0;
    step(); expect_all("race_drain", DRAIN, 1, 0, 3'b011, 1, 1, 0);
    i_tick = 1'b0; i_sw_vio = 4'b1011; i_sel_vio = 1'b1;
    step(); expect_all("race_back", RUN, 1, 0, 3'b011, 1, 1, 0);
    i_tick = 1'b1;
    step(); expect_all("race_tick", RUN, 1, 0, 3'b011, 1, 1, 0);
    i_tick = 1'b0;

    // VIO soft reset in RUN: one CLEAR cycle
    i_reset_vio = 1'b1;
    step(); expect_all("vio_rst_clear", CLEAR, 0, 1, 3'b011, 1, 1, 0);
    i_reset_vio = 1'b0;
    step(); expect_all("vio_rst_run", RUN, 1, 0, 3'b011, 1, 1, 0);
    step(); check("vio_rst_once", 32'(o_clear), 32'h0);

    // DRAIN timeout after 20 cycles back to board
    i_sel_vio = 1'b0;
    step(); check("to_drain", 32'(o_state), 32'(DRAIN));
    for (int i = 0; i < 19; i++) begin
      step();
      check("timeout_hold", 32'(o_state), 32'(DRAIN));
    end
    step(); expect_all("timeout_clear", CLEAR, 0, 1, 3'b011, 1, 1, 0);
    step(); expect_all("timeout_run", RUN, 1, 0, 3'b001, 0, 0, 0);

    // Request withdrawn after 4 cycles: back to RUN without clear
    i_sel_vio = 1'b1;
    step(); check("abort_drain", 32'(o_state), 32'(DRAIN));
    for (int i = 0; i < 3; i++) begin
      step();
      check("abort_state", 32'(o_state), 32'(DRAIN));
      check("abort_noclr", 32'(o_clear), 32'h0);
    end
    i_sel_vio = 1'b0;
    step(); expect_all("abort_run", RUN, 1, 0, 3'b001, 0, 0, 0);

    // Hard reset mid-DRAIN
    i_sel_vio = 1'b1;
    step(); step();
    check("pre_rst_drain", 32'(o_state), 32'(DRAIN));
    i_reset = 1'b1;
    step(); expect_all("rst_in_drain", IDLE, 0, 0, 3'b000, 0, 0, 0);
    i_reset = 1'b0; i_sel_vio = 1'b0;
    step(); check("rst_release", 32'(o_state), 32'(CLEAR));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
